// File: rtl/elevator_ctrl.sv
// SCAN-order elevator controller: latches per-floor calls, times travel between
// floors and door dwell, and keeps its direction while requests remain ahead.
module elevator_ctrl #(
    parameter int NUM_FLOORS    = 8,
    parameter int FLOOR_W       = 3,
    parameter int TRAVEL_CYCLES = 16,
    parameter int DOOR_CYCLES   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] call_req,
    output logic                  motor_up,
    output logic                  motor_down,
    output logic                  open_door,
    output logic                  close_door,
    output logic [FLOOR_W-1:0]    floor,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  dir_up,
    output logic                  busy
);
    localparam int TW = $clog2(TRAVEL_CYCLES + 1);
    localparam int DW = $clog2(DOOR_CYCLES + 1);
    localparam logic [TW-1:0] TRAVEL_LAST = TW'(TRAVEL_CYCLES - 1);
    localparam logic [DW-1:0] DOOR_LAST   = DW'(DOOR_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN} state_t;

    state_t                  state_q, state_d;
    logic [FLOOR_W-1:0]      floor_q, floor_d;
    logic [NUM_FLOORS-1:0]   pending_q, pending_d;
    logic                    dir_up_q, dir_up_d;
    logic [TW-1:0]           travel_cnt_q, travel_cnt_d;
    logic [DW-1:0]           door_cnt_q, door_cnt_d;
    logic                    above, below, here;
    logic [NUM_FLOORS-1:0]   req_all, clr;
    logic [FLOOR_W-1:0]      next_floor;

    always_comb begin
        above = 1'b0;
        below = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (pending_q[i] && (i > int'(floor_q))) above = 1'b1;
            if (pending_q[i] && (i < int'(floor_q))) below = 1'b1;
        end
    end

    assign here       = pending_q[floor_q];
    // Arrival check sees calls made on the arrival edge itself.
    assign req_all    = pending_q | call_req;
    assign next_floor = (state_q == MOVE_UP) ? floor_q + FLOOR_W'(1) : floor_q - FLOOR_W'(1);

    always_comb begin
        state_d      = state_q;
        floor_d      = floor_q;
        dir_up_d     = dir_up_q;
        travel_cnt_d = travel_cnt_q;
        door_cnt_d   = door_cnt_q;
        clr          = '0;
        case (state_q)
            IDLE: begin
                if (here) begin
                    state_d         = DOOR_OPEN;
                    door_cnt_d      = '0;
                    clr[floor_q]    = 1'b1;
                end else if (above && (dir_up_q || !below)) begin
                    state_d      = MOVE_UP;
                    dir_up_d     = 1'b1;
                    travel_cnt_d = '0;
                end else if (below) begin
                    state_d      = MOVE_DOWN;
                    dir_up_d     = 1'b0;
                    travel_cnt_d = '0;
                end
            end
            MOVE_UP, MOVE_DOWN: begin
                if (travel_cnt_q == TRAVEL_LAST) begin
                    travel_cnt_d = '0;
                    floor_d      = next_floor;
                    if (req_all[next_floor]) begin
                        state_d         = DOOR_OPEN;
                        door_cnt_d      = '0;
                        clr[next_floor] = 1'b1;
                    end
                end else begin
                    travel_cnt_d = travel_cnt_q + TW'(1);
                end
            end
            DOOR_OPEN: begin
                // A same-floor call while open re-arms the dwell instead of queuing.
                if (call_req[floor_q]) begin
                    door_cnt_d   = '0;
                    clr[floor_q] = 1'b1;
                end else if (door_cnt_q == DOOR_LAST) begin
                    door_cnt_d   = '0;
                    travel_cnt_d = '0;
                    if (dir_up_q && above) begin
                        state_d = MOVE_UP;
                    end else if (below) begin
                        state_d  = MOVE_DOWN;
                        dir_up_d = 1'b0;
                    end else if (above) begin
                        state_d  = MOVE_UP;
                        dir_up_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    door_cnt_d = door_cnt_q + DW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        pending_d = req_all & ~clr;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            floor_q      <= '0;
            pending_q    <= '0;
            dir_up_q     <= 1'b1;
            travel_cnt_q <= '0;
            door_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            floor_q      <= floor_d;
            pending_q    <= pending_d;
            dir_up_q     <= dir_up_d;
            travel_cnt_q <= travel_cnt_d;
            door_cnt_q   <= door_cnt_d;
        end
    end

    assign motor_up   = (state_q == MOVE_UP);
    assign motor_down = (state_q == MOVE_DOWN);
    assign open_door  = (state_q == DOOR_OPEN);
    assign close_door = ~open_door;
    assign floor      = floor_q;
    assign pending    = pending_q;
    assign dir_up     = dir_up_q;
    assign busy       = (state_q != IDLE) || (|pending_q);
endmodule
